// File: rtl/pipeline_stall_ctrl.sv
// IF/ID register owner and front-end stall/flush/freeze control.
// Decodes one event per cycle and tracks stall/flush statistics.
module pipeline_stall_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_wait,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc_plus4,
  output logic             pc_write,
  output logic             ex_bubble,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc_plus4,
  output logic             id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_timeout
);

  localparam int RW = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_instr;
  logic [31:0]      r_pc4;
  logic             r_valid;
  logic [CNT_W-1:0] r_scnt;
  logic [CNT_W-1:0] r_fcnt;
  logic             r_tout;
  logic [RW-1:0]    r_run;

  logic          w_ev_rst;
  logic          w_ev_frz;
  logic          w_ev_fl;
  logic          w_ev_st;
  logic          w_ev_nrm;
  logic [RW-1:0] w_run_base;
  logic [RW-1:0] w_run_nxt;

  // one-hot event decode in priority order
  assign w_ev_rst = rst;
  assign w_ev_frz = !rst && mem_wait;
  assign w_ev_fl  = !rst && !mem_wait &&
                    (branch_taken || jump);
  assign w_ev_st  = !rst && !mem_wait &&
                    !(branch_taken || jump) &&
                    load_use_stall;
  assign w_ev_nrm = !rst && !mem_wait &&
                    !(branch_taken || jump) &&
                    !load_use_stall;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // next state from the current event
  always_comb begin
    w_state_nxt = RUN;
    unique case (1'b1)
      w_ev_rst: w_state_nxt = RUN;
      w_ev_frz: w_state_nxt = FREEZE;
      w_ev_fl:  w_state_nxt = RUN;
      w_ev_st:  w_state_nxt = STALL;
      w_ev_nrm: w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  // PC enable and bubble decoded from the current event
  always_comb begin
    pc_write  = 1'b0;
    ex_bubble = 1'b0;
    unique case (1'b1)
      w_ev_rst: ;
      w_ev_frz: ;
      w_ev_fl:  pc_write = 1'b1;
      w_ev_st:  ex_bubble = 1'b1;
      w_ev_nrm: pc_write = 1'b1;
      default:  ;
    endcase
  end

  // consecutive-stall run length; freeze holds it
  always_comb begin
    w_run_base = (r_state == RUN) ? '0 : r_run;
    w_run_nxt  = '0;
    if (w_state_nxt == FREEZE)
      w_run_nxt = r_run;
    else if (w_state_nxt == STALL)
      w_run_nxt = (w_run_base < RW'(MAX_STALL)) ?
                  w_run_base + 1'b1 : w_run_base;
  end

  // IF/ID register, counters and sticky timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_scnt  <= '0;
      r_fcnt  <= '0;
      r_tout  <= 1'b0;
      r_run   <= '0;
    end else begin
      r_run <= w_run_nxt;
      if (w_ev_nrm) begin
        r_instr <= if_instr;
        r_pc4   <= if_pc_plus4;
        r_valid <= 1'b1;
      end
      if (w_ev_fl) begin
        r_instr <= NOP_INSTR;
        r_pc4   <= if_pc_plus4;
        r_valid <= 1'b0;
        if (r_fcnt != '1)
          r_fcnt <= r_fcnt + 1'b1;
      end
      if (w_ev_st) begin
        if (r_scnt != '1)
          r_scnt <= r_scnt + 1'b1;
        if (w_run_nxt >= RW'(MAX_STALL))
          r_tout <= 1'b1;
      end
    end
  end

  assign id_instr      = r_instr;
  assign id_pc_plus4   = r_pc4;
  assign id_valid      = r_valid;
  assign stall_count   = r_scnt;
  assign flush_count   = r_fcnt;
  assign stall_timeout = r_tout;

endmodule
